lenet_layer_scheduler: RTL and testbench
========================================

Name: lenet_layer_scheduler

Overview:
- Top-level sequencer for the LeNet accelerator. On `start` it runs layers 0..NUM_LAYERS-1 (conv_1, pool_1, conv_2, pool_2, fc_1, fc_2) strictly in order, one at a time.
- It holds each layer's enable until that layer reports finish, then moves to the next layer.
- It also multiplexes the single shared bias/weights BRAM port and the single shared result BRAM port to whichever layer is active.
- A watchdog detects a layer that never finishes.

Parameters:
- NUM_LAYERS, 6, number of sequenced layers; index 0 runs first.
- DATA_SIZE, 8, BRAM data width.
- WADDR_W, 19, bias/weights BRAM address width.
- RADDR_W, 15, result BRAM address width.
- TIMEOUT_CYCLES, 2**24, maximum cycles a layer may stay enabled before an error is raised.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  pulse; begins a full run. Accepted only in S_IDLE.
- busy  out  1  high from the cycle after start is accepted until S_DONE or S_ERROR.
- done  out  1  one-cycle pulse when the last layer finishes.
- error  out  1  sticky; set on watchdog expiry, cleared by the next accepted start.
- layer_idx  out  3  index of the current/last layer.
- layer_en  out  NUM_LAYERS  one-hot enable to the layers.
- layer_finish  in  NUM_LAYERS  finish flags from the layers.
- lyr_bw_ena  in  NUM_LAYERS  per-layer weights-BRAM enable.
- lyr_bw_addra  in  NUM_LAYERS*WADDR_W  per-layer weights address; layer i occupies slice i.
- lyr_res_ena  in  NUM_LAYERS  per-layer result-BRAM enable.
- lyr_res_wea  in  NUM_LAYERS  per-layer result-BRAM write enable.
- lyr_res_addra  in  NUM_LAYERS*RADDR_W  per-layer result address.
- lyr_res_dina  in  NUM_LAYERS*DATA_SIZE  per-layer result write data.
- bias_weights_bram_ena  out  1  shared weights-BRAM port enable.
- bias_weights_bram_addra  out  WADDR_W  shared weights-BRAM port address.
- result_bram_ena  out  1  shared result-BRAM port enable.
- result_bram_wea  out  1  shared result-BRAM port write enable.
- result_bram_addra  out  RADDR_W  shared result-BRAM port address.
- result_bram_dina  out  DATA_SIZE  shared result-BRAM port write data.

Behaviour:
- Reset (asynchronous, any time including mid-run):
  - state=S_IDLE; busy=0, done=0, error=0, layer_idx=0, layer_en=0.
  - All shared BRAM outputs are 0; guard and watchdog counters are 0.
- States:
  - S_IDLE: on start, go to S_LAUNCH. Set layer_idx=0, error=0, busy=1.
  - S_LAUNCH: layer_en <= one-hot(layer_idx). Clear guard and watchdog. Go to S_RUN.
  - S_RUN:
    - guard counts 0..2 and saturates. layer_finish[layer_idx] is ignored while guard<2; the layers' finish flag is stale from their previous run until their own idle state clears it.
    - If guard==2 and layer_finish[layer_idx]=1: layer_en <= 0 on the same edge; the layer freezes holding finish. If layer_idx==NUM_LAYERS-1 go to S_DONE, else go to S_GAP.
    - Else if watchdog==TIMEOUT_CYCLES-1: layer_en <= 0, error <= 1, go to S_ERROR.
  - S_GAP: one idle cycle with no enable and a released bus. layer_idx <= layer_idx+1. Go to S_LAUNCH.
  - S_DONE: done=1 for exactly this cycle, busy=0. Go to S_IDLE.
  - S_ERROR: busy=0. Go to S_IDLE. error remains set.
- Launch latency:
  - start accepted at edge N gives layer_en[0]=1 after edge N+1.
  - Between layer k's finish being sampled and layer k+1 being enabled there are 3 cycles (RUN→GAP→LAUNCH).
- start while busy: ignored. start in the same cycle as S_DONE: ignored; it is accepted only from S_IDLE.
- Bus mux:
  - Combinational, selected by the registered layer_idx and gated by a registered grant. grant=1 only in S_RUN.
  - With grant=0, all shared outputs are 0.
  - Inputs from non-selected layers are ignored entirely, even if they assert ena or wea.
  - A layer still asserting ena or wea after finish is masked, because grant drops on leaving S_RUN.
- Multiple layer_finish bits set: only bit layer_idx matters.
- watchdog: 25-bit counter, increments each S_RUN cycle, cleared in S_LAUNCH.

Decomposition:
- Package lenet_pkg holds:
  - the DATA_SIZE, WADDR_W and RADDR_W constants;
  - the layer index constants L_CONV1=0 … L_FC2=5;
  - the state encoding (one-hot, 6 bits).
- One sub-module: lenet_bram_port_mux.
  - Parameterised N-way select of {ena, wea, addr, din} with grant gating.
  - Instantiated twice: once for the weights port (wea/din tied 0) and once for the result port.

Test Plan:
- Nominal run: stub layers finish after 10, 5, 20, 5, 8, 3 cycles. Require:
  - layer_en walks 000001→100000 with a 3-cycle gap between layers;
  - done pulses exactly once, 1 cycle long;
  - busy falls with done;
  - error=0.
- Stale finish: all layer_finish held 1 before start. Require that each layer stays enabled for ≥2 cycles (the guard) and that no layer is skipped.
- Bus isolation:
  - While layer 2 runs, layers 0 and 3 drive result_bram_ena=1, wea=1, addr=0x1234. Require shared result_bram_* to follow only layer 2's values, e.g. addr=14400, din=0x5A.
  - In S_GAP all shared outputs are 0.
- Watchdog: TIMEOUT_CYCLES=16, layer 1 never finishes. Require:
  - layer_en clears after 16 cycles in S_RUN;
  - error=1 and busy=0;
  - a new start clears error and restarts at layer 0.
- Async reset mid-run: assert rst asynchronously (not on a clock edge) during layer 3. Require layer_en=0, all BRAM outputs 0 and busy=0 immediately, without waiting for a clock edge.
- start during busy, and start in the S_DONE cycle: both ignored. A start one cycle later is accepted.

Source files
------------

// File: rtl/lenet_pkg.sv
// Shared constants and types for the LeNet layer scheduler.
//   DATA_SIZE / WADDR_W / RADDR_W : BRAM data and address widths
//   L_CONV1 .. L_FC2              : layer indices in execution order
//   state_t                       : one-hot scheduler state encoding
package lenet_pkg;

    localparam int DATA_SIZE   = 8;
    localparam int WADDR_W     = 19;
    localparam int RADDR_W     = 15;
    localparam int LAYER_IDX_W = 3;
    localparam int WDOG_W      = 25;

    localparam logic [LAYER_IDX_W-1:0] L_CONV1 = 3'd0;
    localparam logic [LAYER_IDX_W-1:0] L_POOL1 = 3'd1;
    localparam logic [LAYER_IDX_W-1:0] L_CONV2 = 3'd2;
    localparam logic [LAYER_IDX_W-1:0] L_POOL2 = 3'd3;
    localparam logic [LAYER_IDX_W-1:0] L_FC1   = 3'd4;
    localparam logic [LAYER_IDX_W-1:0] L_FC2   = 3'd5;

    typedef enum logic [5:0] {
        S_IDLE   = 6'b000001,
        S_LAUNCH = 6'b000010,
        S_RUN    = 6'b000100,
        S_GAP    = 6'b001000,
        S_DONE   = 6'b010000,
        S_ERROR  = 6'b100000
    } state_t;

endpackage

// File: rtl/lenet_layer_scheduler_if.sv
// Bundle between the scheduler and its environment (host, layers, BRAMs).
//   master : scheduler side (drives status, layer enables, shared BRAM port)
//   slave  : environment side (drives start, layer finish flags, per-layer BRAM requests)
interface lenet_layer_scheduler_if #(
    parameter int NUM_LAYERS = 6
);
    import lenet_pkg::*;

    logic                          start;
    logic                          busy;
    logic                          done;
    logic                          error;
    logic [LAYER_IDX_W-1:0]        layer_idx;
    logic [NUM_LAYERS-1:0]         layer_en;
    logic [NUM_LAYERS-1:0]         layer_finish;

    logic [NUM_LAYERS-1:0]         lyr_bw_ena;
    logic [NUM_LAYERS*WADDR_W-1:0] lyr_bw_addra;
    logic [NUM_LAYERS-1:0]         lyr_res_ena;
    logic [NUM_LAYERS-1:0]         lyr_res_wea;
    logic [NUM_LAYERS*RADDR_W-1:0] lyr_res_addra;
    logic [NUM_LAYERS*DATA_SIZE-1:0] lyr_res_dina;

    logic                          bias_weights_bram_ena;
    logic [WADDR_W-1:0]            bias_weights_bram_addra;
    logic                          result_bram_ena;
    logic                          result_bram_wea;
    logic [RADDR_W-1:0]            result_bram_addra;
    logic [DATA_SIZE-1:0]          result_bram_dina;

    modport master (
        input  start, layer_finish,
        input  lyr_bw_ena, lyr_bw_addra, lyr_res_ena, lyr_res_wea, lyr_res_addra, lyr_res_dina,
        output busy, done, error, layer_idx, layer_en,
        output bias_weights_bram_ena, bias_weights_bram_addra,
        output result_bram_ena, result_bram_wea, result_bram_addra, result_bram_dina
    );

    modport slave (
        output start, layer_finish,
        output lyr_bw_ena, lyr_bw_addra, lyr_res_ena, lyr_res_wea, lyr_res_addra, lyr_res_dina,
        input  busy, done, error, layer_idx, layer_en,
        input  bias_weights_bram_ena, bias_weights_bram_addra,
        input  result_bram_ena, result_bram_wea, result_bram_addra, result_bram_dina
    );

endinterface

// File: rtl/lenet_bram_port_mux.sv
// N-way selector onto one shared BRAM port, gated by a grant.
//   grant     : when low every shared output is 0
//   sel       : index of the requester that owns the port
//   ena/wea   : per-requester enables, bit i = requester i
//   addr/din  : per-requester address/data, slice i = requester i
//   port_*    : shared BRAM port
module lenet_bram_port_mux
    import lenet_pkg::*;
#(
    parameter int N     = 6,
    parameter int SEL_W = LAYER_IDX_W,
    parameter int AW    = WADDR_W,
    parameter int DW    = DATA_SIZE
) (
    input  logic            grant,
    input  logic [SEL_W-1:0] sel,
    input  logic [N-1:0]    ena,
    input  logic [N-1:0]    wea,
    input  logic [N*AW-1:0] addr,
    input  logic [N*DW-1:0] din,
    output logic            port_ena,
    output logic            port_wea,
    output logic [AW-1:0]   port_addr,
    output logic [DW-1:0]   port_din
);

    always_comb begin
        port_ena  = 1'b0;
        port_wea  = 1'b0;
        port_addr = '0;
        port_din  = '0;
        if (grant) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (32'(sel) == i) begin
                    port_ena  = ena[i];
                    port_wea  = wea[i];
                    port_addr = addr[i*AW +: AW];
                    port_din  = din[i*DW +: DW];
                end
            end
        end
    end

endmodule

// File: rtl/lenet_layer_scheduler.sv
// Top-level LeNet sequencer: runs layers 0..NUM_LAYERS-1 one at a time on start,
// owns the shared weights and result BRAM ports, and raises a sticky error when a
// layer stays enabled for TIMEOUT_CYCLES without finishing.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : start/busy/done/error, layer enables and finish flags, per-layer
//              BRAM requests in, shared BRAM ports out
module lenet_layer_scheduler
    import lenet_pkg::*;
#(
    parameter int          NUM_LAYERS     = 6,
    parameter int unsigned TIMEOUT_CYCLES = 2**24
) (
    input  logic clk,
    input  logic rst,
    lenet_layer_scheduler_if.master bus
);

    state_t                 state, state_nxt;
    logic [LAYER_IDX_W-1:0] idx, idx_nxt;
    logic [NUM_LAYERS-1:0]  en, en_nxt;
    logic                   err, err_nxt;
    logic [1:0]             guard, guard_nxt;
    logic [WDOG_W-1:0]      wdog, wdog_nxt;
    logic                   grant;

    logic                   unused_wgt_wea;
    logic                   unused_wgt_din;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
            en    <= '0;
            err   <= 1'b0;
            guard <= '0;
            wdog  <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            en    <= en_nxt;
            err   <= err_nxt;
            guard <= guard_nxt;
            wdog  <= wdog_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        en_nxt    = en;
        err_nxt   = err;
        guard_nxt = guard;
        wdog_nxt  = wdog;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = S_LAUNCH;
                    idx_nxt   = '0;
                    err_nxt   = 1'b0;
                end
            end
            S_LAUNCH: begin
                en_nxt    = NUM_LAYERS'(1) << idx;
                guard_nxt = '0;
                wdog_nxt  = '0;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                // A layer's finish flag is left over from its previous run until
                // its own idle state clears it, so ignore it for two cycles.
                if (guard != 2'd2)
                    guard_nxt = guard + 2'd1;
                wdog_nxt = wdog + WDOG_W'(1);
                if (guard == 2'd2 && bus.layer_finish[idx]) begin
                    en_nxt    = '0;
                    state_nxt = (idx == LAYER_IDX_W'(NUM_LAYERS - 1)) ? S_DONE : S_GAP;
                end else if (wdog == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
                    en_nxt    = '0;
                    err_nxt   = 1'b1;
                    state_nxt = S_ERROR;
                end
            end
            S_GAP: begin
                idx_nxt   = idx + LAYER_IDX_W'(1);
                state_nxt = S_LAUNCH;
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERROR: state_nxt = S_IDLE;
            default: begin
                state_nxt = S_IDLE;
                en_nxt    = '0;
            end
        endcase
    end

    // The bus is only granted while a layer is running, so any request a layer
    // leaves asserted after finishing is masked from the gap onward.
    assign grant         = (state == S_RUN);
    assign bus.busy      = (state == S_LAUNCH) || (state == S_RUN) || (state == S_GAP);
    assign bus.done      = (state == S_DONE);
    assign bus.error     = err;
    assign bus.layer_idx = idx;
    assign bus.layer_en  = en;

    lenet_bram_port_mux #(
        .N     (NUM_LAYERS),
        .SEL_W (LAYER_IDX_W),
        .AW    (WADDR_W),
        .DW    (1)
    ) u_weights_mux (
        .grant     (grant),
        .sel       (idx),
        .ena       (bus.lyr_bw_ena),
        .wea       ('0),
        .addr      (bus.lyr_bw_addra),
        .din       ('0),
        .port_ena  (bus.bias_weights_bram_ena),
        .port_wea  (unused_wgt_wea),
        .port_addr (bus.bias_weights_bram_addra),
        .port_din  (unused_wgt_din)
    );

    lenet_bram_port_mux #(
        .N     (NUM_LAYERS),
        .SEL_W (LAYER_IDX_W),
        .AW    (RADDR_W),
        .DW    (DATA_SIZE)
    ) u_result_mux (
        .grant     (grant),
        .sel       (idx),
        .ena       (bus.lyr_res_ena),
        .wea       (bus.lyr_res_wea),
        .addr      (bus.lyr_res_addra),
        .din       (bus.lyr_res_dina),
        .port_ena  (bus.result_bram_ena),
        .port_wea  (bus.result_bram_wea),
        .port_addr (bus.result_bram_addra),
        .port_din  (bus.result_bram_dina)
    );

endmodule

// File: tb/tb_lenet_layer_scheduler.sv
// Self-checking bench for lenet_layer_scheduler: stub layers, a launch scoreboard,
// per-cycle shared-bus expectations, plus a second instance with a short watchdog.
module tb_lenet_layer_scheduler;
    import lenet_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lenet_layer_scheduler_if #(.NUM_LAYERS(6)) bus ();
    lenet_layer_scheduler_if #(.NUM_LAYERS(6)) bus_wd ();

    lenet_layer_scheduler #(.NUM_LAYERS(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    lenet_layer_scheduler #(.NUM_LAYERS(6), .TIMEOUT_CYCLES(16)) dut_wd (
        .clk (clk),
        .rst (rst),
        .bus (bus_wd)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Per-layer BRAM request tables (constant for the whole run).
    logic [5:0]  bw_ena_t = 6'b110111;
    logic [18:0] bw_addr_t [6] = '{19'h10000, 19'h10321, 19'h10642, 19'h10963, 19'h10C84, 19'h10FA5};
    logic        res_ena_t [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        res_wea_t [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [14:0] res_addr_t[6] = '{15'h1234, 15'h7FFF, 15'd14400, 15'h1234, 15'd100, 15'h7FFF};
    logic [7:0]  res_din_t [6] = '{8'hA5, 8'hFF, 8'h5A, 8'hA5, 8'h11, 8'hFF};

    // Stub layers: finish after lens[i] enabled cycles; the stale flag is cleared
    // on the second enabled cycle and finish is held once set.
    int   lens [6] = '{10, 5, 20, 5, 8, 3};
    int   cnt  [6] = '{0, 0, 0, 0, 0, 0};
    logic [5:0] fin = '0;
    bit   force_fin = 1'b0;

    always @(negedge clk) begin
        for (int i = 0; i < 6; i++) begin
            if (rst || !bus.layer_en[i]) begin
                cnt[i] = 0;
            end else begin
                if (cnt[i] == 1) fin[i] = 1'b0;
                if (cnt[i] == lens[i] - 1) fin[i] = 1'b1;
                cnt[i] = cnt[i] + 1;
            end
        end
        bus.layer_finish = fin | {6{force_fin}};
    end

    // Launch scoreboard: expected (layer, enabled duration) pushed when a run is started.
    typedef struct {
        int idx;
        int dur;
    } launch_t;

    launch_t    exp_q[$];
    launch_t    cur;
    int         cyc = 0;
    int         start_cyc = 0;
    int         last_hi_cyc = 0;
    int         done_cnt = 0;
    bit         in_layer = 1'b0;
    logic [5:0] prev_en = '0;
    logic [44:0] exp_bus;

    task automatic push_run(input bit stale);
        for (int i = 0; i < 6; i++) begin
            launch_t e;
            e.idx = i;
            e.dur = stale ? 3 : lens[i];
            exp_q.push_back(e);
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            exp_q.delete();
            in_layer = 1'b0;
            prev_en  = '0;
        end else begin
            exp_bus = '0;
            for (int i = 0; i < 6; i++)
                if (bus.layer_en[i])
                    exp_bus = {bw_ena_t[i], bw_addr_t[i], res_ena_t[i], res_wea_t[i],
                               res_addr_t[i], res_din_t[i]};
            check("shared_bus",
                  {bus.bias_weights_bram_ena, bus.bias_weights_bram_addra, bus.result_bram_ena,
                   bus.result_bram_wea, bus.result_bram_addra, bus.result_bram_dina}, exp_bus);
            if (bus.done) done_cnt++;
            if (bus.layer_en != '0 && prev_en == '0) begin
                if (exp_q.size() == 0) begin
                    check("spurious_launch", bus.layer_en, 0);
                end else begin
                    cur = exp_q.pop_front();
                    check("launch_onehot", bus.layer_en, 64'd1 << cur.idx);
                    if (cur.idx != 0) check("launch_gap", cyc - last_hi_cyc, 3);
                    start_cyc = cyc;
                    in_layer  = 1'b1;
                end
            end else if (bus.layer_en == '0 && prev_en != '0 && in_layer) begin
                check("layer_dur", cyc - start_cyc, cur.dur);
                in_layer = 1'b0;
            end
            if (bus.layer_en != '0) last_hi_cyc = cyc;
            prev_en = bus.layer_en;
        end
    end

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            tick();
            if (bus.done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, seen, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got time %0t, expected run to finish", $time);
        $fatal(1);
    end

    initial begin
        int n;
        int dc;

        bus.start    = 1'b0;
        bus.lyr_bw_ena  = bw_ena_t;
        bus.lyr_res_ena = '0;
        bus.lyr_res_wea = '0;
        for (int i = 0; i < 6; i++) begin
            bus.lyr_bw_addra[i*19 +: 19] = bw_addr_t[i];
            bus.lyr_res_ena[i]           = res_ena_t[i];
            bus.lyr_res_wea[i]           = res_wea_t[i];
            bus.lyr_res_addra[i*15 +: 15] = res_addr_t[i];
            bus.lyr_res_dina[i*8 +: 8]   = res_din_t[i];
        end
        bus_wd.start         = 1'b0;
        bus_wd.layer_finish  = 6'b000001;
        bus_wd.lyr_bw_ena    = '0;
        bus_wd.lyr_bw_addra  = '0;
        bus_wd.lyr_res_ena   = '0;
        bus_wd.lyr_res_wea   = '0;
        bus_wd.lyr_res_addra = '0;
        bus_wd.lyr_res_dina  = '0;

        // Reset values.
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        tick();
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_error", bus.error, 0);
        check("rst_layer_idx", bus.layer_idx, 0);
        check("rst_layer_en", bus.layer_en, 0);

        // Nominal run, with a start pulse while busy.
        dc = done_cnt;
        push_run(1'b0);
        pulse_start();
        check("launch_busy", bus.busy, 1);
        check("launch_en_not_yet", bus.layer_en, 0);
        tick();
        check("launch_en0", bus.layer_en, 6'b000001);
        repeat (3) tick();
        pulse_start();
        check("start_while_busy_busy", bus.busy, 1);
        check("start_while_busy_en", bus.layer_en, 6'b000001);
        wait_done("nominal", 300);
        check("nominal_done_busy", bus.busy, 0);
        check("nominal_error", bus.error, 0);
        check("nominal_last_idx", bus.layer_idx, 5);
        // start presented during the S_DONE cycle must be ignored.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("done_one_cycle", bus.done, 0);
        check("start_in_done_ignored", bus.busy, 0);
        check("nominal_all_launched", exp_q.size(), 0);
        check("nominal_done_count", done_cnt - dc, 1);

        // Stale finish: all flags held high; each layer must still get the guard.
        force_fin = 1'b1;
        dc = done_cnt;
        push_run(1'b1);
        pulse_start();
        check("stale_accept_busy", bus.busy, 1);
        wait_done("stale", 200);
        tick();
        tick();
        check("stale_all_launched", exp_q.size(), 0);
        check("stale_done_count", done_cnt - dc, 1);
        check("stale_error", bus.error, 0);
        force_fin = 1'b0;

        // Watchdog with TIMEOUT_CYCLES=16; layer 1 never finishes.
        bus_wd.start = 1'b1;
        tick();
        bus_wd.start = 1'b0;
        n = 0;
        while (!bus_wd.layer_en[1] && n < 50) begin
            tick();
            n++;
        end
        check("wd_l1_launched", bus_wd.layer_en, 6'b000010);
        check("wd_no_error_yet", bus_wd.error, 0);
        n = 0;
        while (bus_wd.layer_en[1] && n < 50) begin
            n++;
            tick();
        end
        check("wd_run_cycles", n, 16);
        check("wd_error", bus_wd.error, 1);
        check("wd_busy", bus_wd.busy, 0);
        check("wd_en_clear", bus_wd.layer_en, 0);
        tick();
        check("wd_error_sticky", bus_wd.error, 1);
        bus_wd.start = 1'b1;
        tick();
        bus_wd.start = 1'b0;
        check("wd_restart_error_clr", bus_wd.error, 0);
        check("wd_restart_busy", bus_wd.busy, 1);
        check("wd_restart_idx", bus_wd.layer_idx, 0);
        tick();
        check("wd_restart_en0", bus_wd.layer_en, 6'b000001);

        // Asynchronous reset during layer 3.
        push_run(1'b0);
        pulse_start();
        n = 0;
        while (!bus.layer_en[3] && n < 200) begin
            tick();
            n++;
        end
        check("rst_mid_reached_l3", bus.layer_en, 6'b001000);
        tick();
        #4 rst = 1'b1;
        #1;
        check("arst_layer_en", bus.layer_en, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_bram",
              {bus.bias_weights_bram_ena, bus.bias_weights_bram_addra, bus.result_bram_ena,
               bus.result_bram_wea, bus.result_bram_addra, bus.result_bram_dina}, 0);
        check("arst_wd_en", bus_wd.layer_en, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        tick();
        check("post_rst_busy", bus.busy, 0);
        check("post_rst_idx", bus.layer_idx, 0);
        check("post_rst_error", bus.error, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
